// File: rtl/dram_cmd_scheduler_if.sv
// Request-queue head and DRAM command trace bundle for dram_cmd_scheduler.
// master = request side (queue / trace sink), slave = scheduler.
interface dram_cmd_scheduler_if #(
    parameter int unsigned ADDR_W = 33
);
    logic              req_valid;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              cmd_valid;
    logic [2:0]        cmd;
    logic [1:0]        cmd_bg;
    logic [1:0]        cmd_bank;
    logic [14:0]       cmd_row;
    logic [10:0]       cmd_col;
    logic              busy;

    modport master (
        output req_valid, req_op, req_addr,
        input  req_ready, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, busy
    );

    modport slave (
        input  req_valid, req_op, req_addr,
        output req_ready, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, busy
    );
endinterface

// File: rtl/dram_cmd_scheduler.sv
// Open-page DDR4 command scheduler: turns the queue-head request into PRE/ACT/RD/WR under tRCD/tRP/tRAS/tCCD.
// Optional `define CLOSED_PAGE_EN: auto-precharge the bank after every column command.
module dram_cmd_scheduler #(
    parameter int unsigned T_RCD   = 24,
    parameter int unsigned T_RP    = 24,
    parameter int unsigned T_RAS   = 52,
    parameter int unsigned T_BURST = 4,
    parameter int unsigned ADDR_W  = 33
) (
    input  logic                 clk,
    input  logic                 rst,
    dram_cmd_scheduler_if.slave  bus
);
    localparam int unsigned NUM_BANKS = 16;
    localparam int unsigned ROW_W     = 15;
    localparam int unsigned COL_W     = 11;
    localparam int unsigned T_MAX_A   = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int unsigned T_MAX_B   = (T_RAS > T_BURST) ? T_RAS : T_BURST;
    localparam int unsigned T_MAX     = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned CNT_W     = $clog2(T_MAX + 1);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

`ifdef CLOSED_PAGE_EN
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_COL, S_AUTO_PRE} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_COL} state_e;
`endif

    state_e state_q, state_nxt;

    logic             op_wr_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [1:0]       bg_q;
    logic [1:0]       bank_q;
    logic [3:0]       cur_idx;

    logic [NUM_BANKS-1:0] open_q;
    logic [ROW_W-1:0]     open_row_q [NUM_BANKS];
    logic [CNT_W-1:0]     ras_cnt_q  [NUM_BANKS];
    logic [CNT_W-1:0]     wait_cnt_q;
    logic [CNT_W-1:0]     ccd_cnt_q;

    logic             req_ready_q, cmd_valid_q, busy_q;
    logic [2:0]       cmd_q;
    logic [1:0]       cmd_bg_q, cmd_bank_q;
    logic [ROW_W-1:0] cmd_row_q;
    logic [COL_W-1:0] cmd_col_q;

    logic [2:0] issue;
    logic       pop;
    logic       latch;

    // Address decode of the queue head: bank index is {bg, bank}
    logic [3:0]       dec_idx;
    logic [ROW_W-1:0] dec_row;
    logic [COL_W-1:0] dec_col;
    logic             unused_addr_bits;

    assign dec_idx          = {bus.req_addr[7:6], bus.req_addr[9:8]};
    assign dec_row          = ROW_W'(bus.req_addr[ADDR_W-1:18]);
    assign dec_col          = {bus.req_addr[17:10], bus.req_addr[5:3]};
    assign unused_addr_bits = &{1'b0, bus.req_addr[2:0]};
    assign cur_idx          = {bg_q, bank_q};

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_nxt;
    end

    // Next state and the single command (if any) issued this cycle
    always_comb begin
        state_nxt = state_q;
        issue     = CMD_NOP;
        pop       = 1'b0;
        latch     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    latch = 1'b1;
                    if (!open_q[dec_idx])                       state_nxt = S_ACT;
                    else if (open_row_q[dec_idx] == dec_row)    state_nxt = S_COL;
                    else                                        state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                if (bus.req_valid && wait_cnt_q == '0 && ras_cnt_q[cur_idx] == '0) begin
                    issue     = CMD_PRE;
                    state_nxt = S_ACT;
                end
            end
            S_ACT: begin
                if (bus.req_valid && wait_cnt_q == '0) begin
                    issue     = CMD_ACT;
                    state_nxt = S_COL;
                end
            end
            S_COL: begin
                if (bus.req_valid && wait_cnt_q == '0 && ccd_cnt_q == '0) begin
                    issue = op_wr_q ? CMD_WR : CMD_RD;
                    pop   = 1'b1;
`ifdef CLOSED_PAGE_EN
                    state_nxt = S_AUTO_PRE;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
`ifdef CLOSED_PAGE_EN
            // Request already popped, so this does not wait on req_valid
            S_AUTO_PRE: begin
                if (ras_cnt_q[cur_idx] == '0 && ccd_cnt_q == '0) begin
                    issue     = CMD_PRE;
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            bg_q    <= '0;
            bank_q  <= '0;
        end else if (latch) begin
            op_wr_q <= (bus.req_op == 2'd1);
            row_q   <= dec_row;
            col_q   <= dec_col;
            bg_q    <= bus.req_addr[7:6];
            bank_q  <= bus.req_addr[9:8];
        end
    end

    // Timing counters and per-bank open-row state
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            ccd_cnt_q  <= '0;
            open_q     <= '0;
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                open_row_q[i] <= '0;
                ras_cnt_q[i]  <= '0;
            end
        end else begin
            if (issue == CMD_ACT)      wait_cnt_q <= CNT_W'(T_RCD - 1);
            else if (issue == CMD_PRE) wait_cnt_q <= CNT_W'(T_RP - 1);
            else                       wait_cnt_q <= dec_sat(wait_cnt_q);

            if (issue == CMD_RD || issue == CMD_WR) ccd_cnt_q <= CNT_W'(T_BURST - 1);
            else                                    ccd_cnt_q <= dec_sat(ccd_cnt_q);

            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                if (issue == CMD_ACT && cur_idx == 4'(i)) begin
                    ras_cnt_q[i]  <= CNT_W'(T_RAS - 1);
                    open_q[i]     <= 1'b1;
                    open_row_q[i] <= row_q;
                end else begin
                    ras_cnt_q[i] <= dec_sat(ras_cnt_q[i]);
                    if (issue == CMD_PRE && cur_idx == 4'(i)) open_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            cmd_bg_q    <= '0;
            cmd_bank_q  <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            req_ready_q <= pop;
            cmd_valid_q <= (issue != CMD_NOP);
            cmd_q       <= issue;
            cmd_bg_q    <= (issue != CMD_NOP) ? bg_q : 2'd0;
            cmd_bank_q  <= (issue != CMD_NOP) ? bank_q : 2'd0;
            cmd_row_q   <= (issue == CMD_ACT) ? row_q : '0;
            cmd_col_q   <= (issue == CMD_RD || issue == CMD_WR) ? col_q : '0;
            busy_q      <= (state_nxt != S_IDLE);
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd       = cmd_q;
    assign bus.cmd_bg    = cmd_bg_q;
    assign bus.cmd_bank  = cmd_bank_q;
    assign bus.cmd_row   = cmd_row_q;
    assign bus.cmd_col   = cmd_col_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Self-checking bench for dram_cmd_scheduler: request tables with hand-timed command logs, plus reset corner case.
// Expectations follow CLOSED_PAGE_EN when it is defined.
module tb_dram_cmd_scheduler;
    localparam int unsigned ADDR_W = 33;
    localparam logic [2:0] NOP = 3'd0;
    localparam logic [2:0] ACT = 3'd1;
    localparam logic [2:0] RD  = 3'd2;
    localparam logic [2:0] WR  = 3'd3;
    localparam logic [2:0] PRE = 3'd4;

    logic clk;
    logic rst;

    dram_cmd_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    dram_cmd_scheduler #(
        .T_RCD(24), .T_RP(24), .T_RAS(52), .T_BURST(4), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
    } req_t;

    typedef struct {
        int          cyc;
        logic [2:0]  cmd;
        logic [1:0]  bg;
        logic [1:0]  bank;
        logic [14:0] row;
        logic [10:0] col;
        logic        ready;
    } ev_t;

    req_t reqs[$];
    ev_t  exp_q[$];
    ev_t  got_q[$];

    int cyc;
    int n_checks;
    int n_pass;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [33:0] pack_out();
        return {bus.cmd, bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.req_ready};
    endfunction

    function automatic logic [33:0] pack_ev(input ev_t e);
        return {e.cmd, e.bg, e.bank, e.row, e.col, e.ready};
    endfunction

    task automatic add_req(input logic [1:0] op, input logic [ADDR_W-1:0] addr);
        req_t r;
        r.op   = op;
        r.addr = addr;
        reqs.push_back(r);
    endtask

    task automatic add_ev(input int c, input logic [2:0] k, input logic [1:0] g, input logic [1:0] b,
                          input logic [14:0] r, input logic [10:0] cl, input logic rdy);
        ev_t e;
        e.cyc = c; e.cmd = k; e.bg = g; e.bank = b; e.row = r; e.col = cl; e.ready = rdy;
        exp_q.push_back(e);
    endtask

    task automatic log_sample(input int t0);
        ev_t e;
        if (bus.cmd_valid || bus.req_ready || bus.cmd != NOP) begin
            e.cyc = cyc - t0; e.cmd = bus.cmd; e.bg = bus.cmd_bg; e.bank = bus.cmd_bank;
            e.row = bus.cmd_row; e.col = bus.cmd_col; e.ready = bus.req_ready;
            got_q.push_back(e);
        end
    endtask

    // Feed reqs back-to-back (next head shown as soon as req_ready is seen), then compare the command log
    task automatic run_seq(input string tag);
        int t0;
        int idx;
        int budget;
        got_q.delete();
        idx    = 0;
        budget = 0;
        bus.req_op    = reqs[0].op;
        bus.req_addr  = reqs[0].addr;
        bus.req_valid = 1'b1;
        t0 = cyc + 1;
        while (idx < reqs.size() && budget < 2000) begin
            step();
            budget++;
            if (cyc == t0) begin
                check({tag, " decode busy"}, 64'(bus.busy), 64'd1);
                check({tag, " decode no cmd"}, 64'(bus.cmd_valid), 64'd0);
            end
            log_sample(t0);
            if (bus.req_ready) begin
                idx++;
                if (idx < reqs.size()) begin
                    bus.req_op   = reqs[idx].op;
                    bus.req_addr = reqs[idx].addr;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        check({tag, " all popped"}, 64'(idx), 64'(reqs.size()));
        bus.req_valid = 1'b0;
        repeat (60) begin
            step();
            log_sample(t0);
        end
        check({tag, " busy at end"}, 64'(bus.busy), 64'd0);
        check({tag, " event count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s ev%0d cycle", tag, i), 64'(got_q[i].cyc), 64'(exp_q[i].cyc));
            check($sformatf("%s ev%0d fields", tag, i), 64'(pack_ev(got_q[i])), 64'(pack_ev(exp_q[i])));
        end
        reqs.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int quiet;
        clk           = 1'b0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_addr  = '0;
        cyc      = 0;
        n_checks = 0;
        n_pass   = 0;

        repeat (3) step();
        check("reset outputs", 64'({bus.cmd_valid, pack_out()}), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;

        quiet = 0;
        repeat (5) begin
            step();
            if (bus.cmd_valid || bus.req_ready || bus.busy) quiet++;
        end
        check("idle without req_valid", 64'(quiet), 64'd0);

`ifdef CLOSED_PAGE_EN
        // Closed page: every request is a closed-bank access followed by PRE
        add_req(2'd0, 33'h0_0004_0000);
        add_req(2'd0, 33'h0_0004_0400);
        add_ev(  1, ACT, 2'd0, 2'd0, 15'd1, 11'd0,   1'b0);
        add_ev( 25, RD,  2'd0, 2'd0, 15'd0, 11'd0,   1'b1);
        add_ev( 53, PRE, 2'd0, 2'd0, 15'd0, 11'd0,   1'b0);
        add_ev( 77, ACT, 2'd0, 2'd0, 15'd1, 11'd0,   1'b0);
        add_ev(101, RD,  2'd0, 2'd0, 15'd0, 11'h008, 1'b1);
        add_ev(129, PRE, 2'd0, 2'd0, 15'd0, 11'd0,   1'b0);
        run_seq("closed");
`else
        // Open page: miss, hit, row conflict, bank parallelism, hit, boundary row/col, op 3 and op 2 as reads
        add_req(2'd0, 33'h0_0004_0000);
        add_req(2'd0, 33'h0_0004_0400);
        add_req(2'd1, 33'h0_0008_0000);
        add_req(2'd0, 33'h0_0014_0100);
        add_req(2'd0, 33'h0_0008_0028);
        add_req(2'd1, 33'h1_FFFF_FEF8);
        add_req(2'd3, 33'h1_FFFC_02C0);
        add_req(2'd2, 33'h1_FFFC_02C8);
        add_ev(  1, ACT, 2'd0, 2'd0, 15'd1,      11'd0,     1'b0);
        add_ev( 25, RD,  2'd0, 2'd0, 15'd0,      11'd0,     1'b1);
        add_ev( 29, RD,  2'd0, 2'd0, 15'd0,      11'h008,   1'b1);
        add_ev( 53, PRE, 2'd0, 2'd0, 15'd0,      11'd0,     1'b0);
        add_ev( 77, ACT, 2'd0, 2'd0, 15'd2,      11'd0,     1'b0);
        add_ev(101, WR,  2'd0, 2'd0, 15'd0,      11'd0,     1'b1);
        add_ev(103, ACT, 2'd0, 2'd1, 15'd5,      11'd0,     1'b0);
        add_ev(127, RD,  2'd0, 2'd1, 15'd0,      11'd0,     1'b1);
        add_ev(131, RD,  2'd0, 2'd0, 15'd0,      11'd5,     1'b1);
        add_ev(133, ACT, 2'd3, 2'd2, 15'h7FFF,   11'd0,     1'b0);
        add_ev(157, WR,  2'd3, 2'd2, 15'd0,      11'h7FF,   1'b1);
        add_ev(161, RD,  2'd3, 2'd2, 15'd0,      11'd0,     1'b1);
        add_ev(165, RD,  2'd3, 2'd2, 15'd0,      11'd1,     1'b1);
        run_seq("open");
`endif

        // Reset 10 cycles after ACT: no pop, request re-decoded against closed banks
        bus.req_op    = 2'd0;
        bus.req_addr  = 33'h0_0024_0340;
        bus.req_valid = 1'b1;
        step();
        check("rst-seq decode busy", 64'(bus.busy), 64'd1);
        step();
        check("rst-seq ACT valid", 64'(bus.cmd_valid), 64'd1);
        check("rst-seq ACT fields", 64'(pack_out()), 64'({ACT, 2'd1, 2'd3, 15'd9, 11'd0, 1'b0}));
        quiet = 0;
        repeat (9) begin
            step();
            if (bus.cmd_valid || bus.req_ready) quiet++;
        end
        check("rst-seq quiet before reset", 64'(quiet), 64'd0);
        rst = 1'b1;
        step();
        check("rst-seq outputs cleared", 64'({bus.cmd_valid, pack_out()}), 64'd0);
        check("rst-seq busy cleared", 64'(bus.busy), 64'd0);
        step();
        check("rst-seq held in reset", 64'({bus.busy, bus.cmd_valid, bus.req_ready}), 64'd0);
        rst = 1'b0;

        add_req(2'd0, 33'h0_0024_0340);
        add_ev( 1, ACT, 2'd1, 2'd3, 15'd9, 11'd0, 1'b0);
        add_ev(25, RD,  2'd1, 2'd3, 15'd0, 11'd0, 1'b1);
`ifdef CLOSED_PAGE_EN
        add_ev(53, PRE, 2'd1, 2'd3, 15'd0, 11'd0, 1'b0);
`endif
        run_seq("after reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
